// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the hardwired control sequencer: opcode classes,
// IR field positions, the sequencer state encoding and a small IR decoder.
package cpu_defs;

   localparam logic [4:0] OP_AND       = 5'b00101;
   localparam logic [4:0] OP_RTYPE_MAX = 5'b01100;
   localparam logic [4:0] OP_NOP       = 5'b11010;
   localparam logic [4:0] OP_HALT      = 5'b11011;

   localparam int OPCODE_LSB = 27;
   localparam int RA_LSB     = 23;
   localparam int RB_LSB     = 19;
   localparam int RC_LSB     = 15;

   typedef enum logic [2:0] {
      ST_RESET = 3'd0,
      ST_T0    = 3'd1,
      ST_T1    = 3'd2,
      ST_T2    = 3'd3,
      ST_T3    = 3'd4,
      ST_T4    = 3'd5,
      ST_T5    = 3'd6,
      ST_HALT  = 3'd7
   } seqState_t;

   typedef struct packed {
      logic [4:0] opcode;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [3:0] rc;
   } irFields_t;

   // Splits the instruction word into opcode and the three register indices.
   function automatic irFields_t decodeIr(input logic [31:0] ir);
      irFields_t f;
      f.opcode = ir[OPCODE_LSB +: 5];
      f.ra     = ir[RA_LSB +: 4];
      f.rb     = ir[RB_LSB +: 4];
      f.rc     = ir[RC_LSB +: 4];
      return f;
   endfunction

   // Three-register ALU instructions occupy the bottom of the opcode space.
   function automatic logic isRtype(input logic [4:0] op);
      return (op <= OP_RTYPE_MAX);
   endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Turns a 4-bit register index into a one-hot 16-bit select, or all zeros
// when the select is not enabled.
module reg_select_decoder (
   input  logic [3:0]  index,
   input  logic        enable,
   output logic [15:0] oneHot
);

   // Only the addressed register line rises, and only while enabled, so the
   // datapath never sees more than one register driving or loading at once.
   always_comb begin
      oneHot = '0;
      if (enable) begin
         oneHot[index] = 1'b1;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus datapath. Fetches through the
// PC/MAR/MDR/IR path, then steps three-register ALU instructions through
// T3..T5. Strobes are a Moore decode of the state register and the live IR.
module control_sequencer
   import cpu_defs::*;
#(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic        Clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        MemRdy,
   output logic        PCout,
   output logic        IncPC,
   output logic        Zin,
   output logic        Zlowout,
   output logic        PCin,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        aluin,
   output logic [4:0]  aluControl,
   output logic [15:0] Rout,
   output logic [15:0] Rin,
   output logic        Run,
   output logic        MemErr
);

   localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

   seqState_t         state;
   seqState_t         nextState;
   logic [WAIT_W-1:0] waitCount;
   logic              releaseSeen;
   logic              memErrReg;
   irFields_t         fields;
   logic              rtype;
   logic              memTimeout;
   logic [3:0]        routIndex;
   logic              routEnable;
   logic              rinEnable;
   logic              unusedIrBits;

   assign fields       = decodeIr(IR);
   assign rtype        = isRtype(fields.opcode);
   assign unusedIrBits = ^IR[14:0];
   assign memTimeout   = (state == ST_T1) && !MemRdy && (waitCount == WAIT_LAST);

   // State register. The reset branch forces RESET so every decoded strobe
   // drops the moment clear goes low, independent of the clock.
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state <= ST_RESET;
      end else begin
         state <= nextState;
      end
   end

   // Remembers that one full clock has passed since clear was released, so
   // RESET is held for exactly one cycle before the first T0.
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         releaseSeen <= 1'b0;
      end else begin
         releaseSeen <= 1'b1;
      end
   end

   // Counts consecutive low MemRdy cycles in T1. It is zeroed while in T0 so
   // every T1 entry starts from zero, which also marks the first T1 cycle.
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         waitCount <= '0;
      end else if (state == ST_T0) begin
         waitCount <= '0;
      end else if ((state == ST_T1) && !MemRdy && (waitCount != WAIT_LAST)) begin
         waitCount <= waitCount + 1'b1;
      end
   end

   // Sticky memory timeout flag; only reset can clear it.
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         memErrReg <= 1'b0;
      end else if (memTimeout) begin
         memErrReg <= 1'b1;
      end
   end

   // Next-state logic: fetch in T0..T2, then either execute an ALU op in
   // T3..T5, skip back to T0 for NOP/illegal, or stop on HALT or timeout.
   always_comb begin
      nextState = state;
      unique case (state)
         ST_RESET: if (releaseSeen) nextState = ST_T0;
         ST_T0:    nextState = ST_T1;
         ST_T1: begin
            if (MemRdy) begin
               nextState = ST_T2;
            end else if (memTimeout) begin
               nextState = ST_HALT;
            end
         end
         ST_T2:    nextState = ST_T3;
         ST_T3: begin
            if (rtype) begin
               nextState = ST_T4;
            end else if (fields.opcode == OP_HALT) begin
               nextState = ST_HALT;
            end else begin
               nextState = ST_T0;
            end
         end
         ST_T4:    nextState = ST_T5;
         ST_T5:    nextState = ST_T0;
         ST_HALT:  nextState = ST_HALT;
         default:  nextState = ST_RESET;
      endcase
   end

   // Strobe decode. Only the first T1 cycle reloads the PC; wait cycles keep
   // the read going without touching the PC again.
   always_comb begin
      PCout      = 1'b0;
      IncPC      = 1'b0;
      Zin        = 1'b0;
      Zlowout    = 1'b0;
      PCin       = 1'b0;
      Read       = 1'b0;
      MDRin      = 1'b0;
      MDRout     = 1'b0;
      IRin       = 1'b0;
      Yin        = 1'b0;
      aluin      = 1'b0;
      aluControl = 5'd0;
      unique case (state)
         ST_T0: begin
            PCout = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         ST_T1: begin
            Read  = 1'b1;
            MDRin = 1'b1;
            if (waitCount == '0) begin
               Zlowout = 1'b1;
               PCin    = 1'b1;
            end
         end
         ST_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         ST_T3: begin
            Yin = rtype;
         end
         ST_T4: begin
            aluin      = 1'b1;
            Zin        = 1'b1;
            aluControl = fields.opcode;
         end
         ST_T5: begin
            Zlowout = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Register select steering: rb drives the bus in T3, rc in T4, and ra is
   // loaded in T5 after both operands have already been read.
   always_comb begin
      routIndex  = (state == ST_T4) ? fields.rc : fields.rb;
      routEnable = ((state == ST_T3) && rtype) || (state == ST_T4);
      rinEnable  = (state == ST_T5);
   end

   reg_select_decoder routDecoder (
      .index  (routIndex),
      .enable (routEnable),
      .oneHot (Rout)
   );

   reg_select_decoder rinDecoder (
      .index  (fields.ra),
      .enable (rinEnable),
      .oneHot (Rin)
   );

   assign Run    = (state != ST_RESET) && (state != ST_HALT);
   assign MemErr = memErrReg;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a table of known instructions,
// hand-written reset/timeout/halt/async-reset sequences, and randomized
// instructions compared cycle by cycle against a micro-op list model.
module tb_control_sequencer;
   import cpu_defs::*;

   localparam int MAX_WAIT = 15;

   localparam logic [10:0] B_PCOUT  = 11'h400;
   localparam logic [10:0] B_INCPC  = 11'h200;
   localparam logic [10:0] B_ZIN    = 11'h100;
   localparam logic [10:0] B_ZLOW   = 11'h080;
   localparam logic [10:0] B_PCIN   = 11'h040;
   localparam logic [10:0] B_READ   = 11'h020;
   localparam logic [10:0] B_MDRIN  = 11'h010;
   localparam logic [10:0] B_MDROUT = 11'h008;
   localparam logic [10:0] B_IRIN   = 11'h004;
   localparam logic [10:0] B_YIN    = 11'h002;
   localparam logic [10:0] B_ALUIN  = 11'h001;

   typedef struct packed {
      logic [10:0] strobes;
      logic [4:0]  alu;
      logic [15:0] rout;
      logic [15:0] rin;
      logic        run;
      logic        err;
   } outRec_t;

   typedef struct {
      string       name;
      logic [31:0] ir;
      int          waits;
      bit          isR;
      logic [15:0] routT3;
      logic [15:0] routT4;
      logic [4:0]  aluT4;
      logic [15:0] rinT5;
      int          nextT0;
   } vec_t;

   logic        Clock = 1'b0;
   logic        clear;
   logic        MemRdy;
   logic [31:0] IR;
   logic [31:0] pendingInstr;
   logic        PCout, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin, aluin;
   logic [4:0]  aluControl;
   logic [15:0] Rout, Rin;
   logic        Run, MemErr;

   int          checks = 0;
   int          failures = 0;
   logic        errModel;
   outRec_t     expQ[$];
   logic        memQ[$];
   outRec_t     obsQ[$];

   always #5 Clock = ~Clock;

   control_sequencer #(.MEM_WAIT_MAX(MAX_WAIT)) dut (
      .Clock(Clock), .clear(clear), .IR(IR), .MemRdy(MemRdy),
      .PCout(PCout), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout), .PCin(PCin),
      .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
      .aluin(aluin), .aluControl(aluControl), .Rout(Rout), .Rin(Rin),
      .Run(Run), .MemErr(MemErr)
   );

   // Stand-in for the datapath instruction register: loads the next
   // instruction word whenever the sequencer pulses IRin.
   always @(posedge Clock or negedge clear) begin
      if (!clear) begin
         IR <= '0;
      end else if (IRin) begin
         IR <= pendingInstr;
      end
   end

   function automatic outRec_t sampleDut();
      outRec_t r;
      r.strobes = {PCout, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin, aluin};
      r.alu     = aluControl;
      r.rout    = Rout;
      r.rin     = Rin;
      r.run     = Run;
      r.err     = MemErr;
      return r;
   endfunction

   function automatic outRec_t mk(input logic [10:0] s, input logic [4:0] a,
                                  input logic [15:0] ro, input logic [15:0] ri,
                                  input logic run);
      outRec_t r;
      r = {s, a, ro, ri, run, errModel};
      return r;
   endfunction

   task automatic checkOutput(input string name, input outRec_t act, input outRec_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got strobes=%h alu=%h rout=%h rin=%h run=%b err=%b, expected strobes=%h alu=%h rout=%h rin=%h run=%b err=%b",
                  name, act.strobes, act.alu, act.rout, act.rin, act.run, act.err,
                  exp.strobes, exp.alu, exp.rout, exp.rin, exp.run, exp.err);
      end
   endtask

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void pushHalted(input int n);
      for (int i = 0; i < n; i++) begin
         expQ.push_back(mk('0, '0, '0, '0, 1'b0));
         memQ.push_back(1'($urandom));
      end
   endfunction

   // Reference model: lists the micro-operations of one instruction, cycle by
   // cycle, with the MemRdy value to present in each cycle.
   function automatic void buildExpected(input logic [31:0] ir, input int waits, input int haltCycles);
      logic [4:0] op;
      logic [3:0] ra, rb, rc;
      int         t1Cycles;
      op = ir[31:27];
      ra = ir[26:23];
      rb = ir[22:19];
      rc = ir[18:15];
      expQ.push_back(mk(B_PCOUT | B_INCPC | B_ZIN, '0, '0, '0, 1'b1));
      memQ.push_back(1'($urandom));
      t1Cycles = (waits >= MAX_WAIT) ? MAX_WAIT : waits + 1;
      for (int k = 0; k < t1Cycles; k++) begin
         expQ.push_back(mk((k == 0) ? (B_ZLOW | B_PCIN | B_READ | B_MDRIN) : (B_READ | B_MDRIN),
                           '0, '0, '0, 1'b1));
         memQ.push_back(k == waits);
      end
      if (waits >= MAX_WAIT) begin
         errModel = 1'b1;
         pushHalted(haltCycles);
         return;
      end
      expQ.push_back(mk(B_MDROUT | B_IRIN, '0, '0, '0, 1'b1));
      memQ.push_back(1'($urandom));
      if (op <= OP_RTYPE_MAX) begin
         expQ.push_back(mk(B_YIN, '0, 16'd1 << rb, '0, 1'b1));
         memQ.push_back(1'($urandom));
         expQ.push_back(mk(B_ZIN | B_ALUIN, op, 16'd1 << rc, '0, 1'b1));
         memQ.push_back(1'($urandom));
         expQ.push_back(mk(B_ZLOW, '0, '0, 16'd1 << ra, 1'b1));
         memQ.push_back(1'($urandom));
      end else begin
         expQ.push_back(mk('0, '0, '0, '0, 1'b1));
         memQ.push_back(1'($urandom));
         if (op == OP_HALT) begin
            pushHalted(haltCycles);
         end
      end
   endfunction

   task automatic applyStimulus(input string tag);
      outRec_t expRec;
      outRec_t act;
      logic    m;
      int      idx;
      idx = 0;
      while (expQ.size() > 0) begin
         expRec = expQ.pop_front();
         m = memQ.pop_front();
         @(negedge Clock);
         MemRdy = m;
         act = sampleDut();
         obsQ.push_back(act);
         checkOutput($sformatf("%s_cyc%0d", tag, idx), act, expRec);
         idx++;
      end
   endtask

   task automatic runInstr(input string tag, input logic [31:0] ir, input int waits, input int haltCycles);
      pendingInstr = ir;
      buildExpected(ir, waits, haltCycles);
      applyStimulus(tag);
   endtask

   task automatic doReset(input string tag);
      clear = 1'b0;
      errModel = 1'b0;
      expQ.delete();
      memQ.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         MemRdy = 1'($urandom);
         checkOutput($sformatf("%s_hold%0d", tag, i), sampleDut(), '0);
      end
      clear = 1'b1;
      @(negedge Clock);
      checkOutput($sformatf("%s_release", tag), sampleDut(), '0);
   endtask

   // Watchdog so the run always ends even if the sequencer wedges.
   initial begin
      #200000;
      failures++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      vec_t        table_v[6];
      int          startIdx[6];
      int          s;
      int          w;
      logic [4:0]  op;
      int          waits;
      logic [31:0] ir;

      table_v[0] = '{"and_r1_r2_r3", 32'h28918000, 0, 1'b1, 16'h0004, 16'h0008, OP_AND, 16'h0002, 6};
      table_v[1] = '{"and_wait3",    32'h28918000, 3, 1'b1, 16'h0004, 16'h0008, OP_AND, 16'h0002, 9};
      table_v[2] = '{"all_r0",       32'h00000000, 1, 1'b1, 16'h0001, 16'h0001, 5'd0,   16'h0001, 7};
      table_v[3] = '{"rtype_max",    32'h67F80000, 0, 1'b1, 16'h8000, 16'h0001, 5'd12,  16'h8000, 6};
      table_v[4] = '{"illegal_op",   32'h68918000, 2, 1'b0, 16'h0000, 16'h0000, 5'd0,   16'h0000, 6};
      table_v[5] = '{"nop",          32'hD0918000, 0, 1'b0, 16'h0000, 16'h0000, 5'd0,   16'h0000, 4};

      clear = 1'b0;
      MemRdy = 1'b0;
      pendingInstr = '0;
      errModel = 1'b0;
      doReset("init");

      for (int i = 0; i < 6; i++) begin
         startIdx[i] = obsQ.size();
         runInstr(table_v[i].name, table_v[i].ir, table_v[i].waits, 0);
      end
      runInstr("tail_nop", {OP_NOP, 27'd0}, 0, 0);

      for (int i = 0; i < 6; i++) begin
         s = startIdx[i];
         w = table_v[i].waits;
         checkValue({table_v[i].name, "_t3_rout"}, 32'(obsQ[s + 3 + w].rout), 32'(table_v[i].routT3));
         if (table_v[i].isR) begin
            checkValue({table_v[i].name, "_t4_rout"}, 32'(obsQ[s + 4 + w].rout), 32'(table_v[i].routT4));
            checkValue({table_v[i].name, "_t4_alu"}, 32'(obsQ[s + 4 + w].alu), 32'(table_v[i].aluT4));
            checkValue({table_v[i].name, "_t5_rin"}, 32'(obsQ[s + 5 + w].rin), 32'(table_v[i].rinT5));
         end else begin
            checkValue({table_v[i].name, "_t3_rin"}, 32'(obsQ[s + 3 + w].rin), 32'd0);
         end
         checkValue({table_v[i].name, "_next_t0"}, 32'(obsQ[s + table_v[i].nextT0].strobes),
                    32'(B_PCOUT | B_INCPC | B_ZIN));
      end

      s = startIdx[1];
      checkValue("wait_pcin_first", 32'(obsQ[s + 1].strobes & B_PCIN), 32'(B_PCIN));
      for (int k = 2; k <= 4; k++) begin
         checkValue($sformatf("wait_pcin_cyc%0d", k), 32'(obsQ[s + k].strobes & B_PCIN), 32'd0);
      end
      checkValue("wait_irin_after_rdy", 32'(obsQ[s + 5].strobes & B_IRIN), 32'(B_IRIN));

      runInstr("halt_op", {OP_HALT, 27'h0123456}, 0, 4);
      checkValue("halt_run", 32'(Run), 32'd0);
      doReset("after_halt");

      runInstr("timeout", 32'h28918000, MAX_WAIT, 4);
      checkValue("timeout_memerr", 32'(MemErr), 32'd1);
      checkValue("timeout_run", 32'(Run), 32'd0);
      doReset("after_timeout");
      checkValue("memerr_cleared", 32'(MemErr), 32'd0);

      pendingInstr = 32'h28918000;
      buildExpected(32'h28918000, 0, 0);
      void'(expQ.pop_back());
      void'(memQ.pop_back());
      applyStimulus("async_to_t4");
      #2;
      clear = 1'b0;
      #1;
      checkValue("async_aluin", 32'(aluin), 32'd0);
      checkValue("async_zin", 32'(Zin), 32'd0);
      checkValue("async_rout", 32'(Rout), 32'd0);
      doReset("after_async");

      for (int n = 0; n < 40; n++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r < 12 || r >= 17) begin
            op = 5'($urandom_range(0, 12));
         end else if (r < 14) begin
            op = OP_NOP;
         end else if (r < 16) begin
            op = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(13, 25)) : 5'($urandom_range(28, 31));
         end else begin
            op = OP_HALT;
         end
         waits = ($urandom_range(0, 15) == 0) ? MAX_WAIT + $urandom_range(0, 2) : $urandom_range(0, 3);
         ir = {op, 27'($urandom)};
         runInstr($sformatf("rand%0d", n), ir, waits, 2);
         if (op == OP_HALT || waits >= MAX_WAIT) begin
            doReset($sformatf("rand%0d_reset", n));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the single-bus datapath. It fetches an instruction through the PC/MAR/MDR/IR path, decodes the opcode and register fields of the IR, and drives every datapath strobe for three-register ALU instructions. It replaces the hand-timed strobe sequences used in datapath benches today: one instruction takes six T-states, plus any memory wait cycles.

## Interface
Parameters:
- `MEM_WAIT_MAX`, default 15: maximum T1 wait cycles before `MemErr` asserts and the block halts.

Ports:
- `Clock`  in  1: single clock; all state changes on the rising edge.
- `clear`  in  1: reset, asynchronous, active-low.
- `IR`  in  32: instruction register contents from the datapath.
- `MemRdy`  in  1: memory read data valid; sampled in T1.
- `PCout, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin, aluin`  out  1 each: datapath strobes.
- `aluControl`  out  5: ALU operation select.
- `Rout`  out  16: one-hot register bus-drive select (bit n → `Rnout`).
- `Rin`  out  16: one-hot register load select (bit n → `Rnin`).
- `Run`  out  1: high while the block is sequencing instructions.
- `MemErr`  out  1: sticky memory-timeout flag.

## Operation
- IR fields: opcode = `IR[31:27]`, ra = `IR[26:23]`, rb = `IR[22:19]`, rc = `IR[18:15]`.
- Opcode classes:
  - R-type ALU: `5'b00000`–`5'b01100`.
  - NOP: `5'b11010`.
  - HALT: `5'b11011`.
  - Every other opcode is treated as NOP.
- States: RESET, T0, T1, T2, T3, T4, T5, HALT.
- Strobe decode (all strobes not listed are 0):
  - RESET: all strobes 0.
  - T0: `PCout`, `IncPC`, `Zin`.
  - T1: `Zlowout`, `PCin`, `Read`, `MDRin`. Applies only to the first T1 cycle. Wait cycles assert `Read` and `MDRin` only, so the PC is not re-loaded.
  - T2: `MDRout`, `IRin`.
  - T3, R-type: `Rout[rb]`, `Yin`.
  - T4: `Rout[rc]`, `aluin`, `Zin`, `aluControl` = opcode.
  - T5: `Zlowout`, `Rin[ra]`.
- `aluControl` is 0 in every state except T4.
- Transitions:
  - RESET → T0.
  - T0 → T1.
  - T1 → T2 when `MemRdy` = 1; otherwise stay in T1.
  - T1 → HALT with `MemErr` set when `MemRdy` has been low for `MEM_WAIT_MAX` consecutive cycles.
  - T2 → T3.
  - T3 → T4 when the opcode is R-type.
  - T3 → T0 when the opcode is NOP or illegal; no strobes are asserted in T3.
  - T3 → HALT when the opcode is HALT.
  - T4 → T5.
  - T5 → T0.
  - HALT → HALT until `clear` asserts.
- `Run` = 1 in T0–T5 and 0 in RESET and HALT.
- ra, rb, or rc equal to 0 selects R0 normally; there is no special case.
- ra equal to rb or rc is legal: R(ra) is written in T5, after both operands were read.

## Timing
- Outputs are a Moore decode of the state register and the current IR. The datapath samples them on the next rising edge.
- Instruction latency: 6 cycles from T0 to the end of T5 with `MemRdy` high in the first T1 cycle. Each low `MemRdy` cycle adds one cycle.
- The IR fields used in T3–T5 come from the IR value loaded at the end of T2.
- Reset:
  - `clear` low forces state RESET, all strobes 0, `Rout`/`Rin` = 0, `Run` = 0, `MemErr` = 0, and the wait counter to 0, immediately and asynchronously, from any state including mid-T1 or mid-T4.
  - The first T0 is the second rising edge after `clear` deasserts.
- The wait counter clears on entry to T1.
- `MemErr` clears only on reset.
- `Rout` and `Rin` are never both nonzero in the same cycle.
- At most one bus driver (`PCout`, `Zlowout`, `MDRout`, or any `Rout` bit) is active in any cycle.

## Structure
- Package `cpu_defs`: opcode constants (`OP_AND` = `5'b00101`, `OP_NOP`, `OP_HALT`, R-type upper bound), state enum encoding, and IR field bit positions.
- One sub-module, `reg_select_decoder`: 4-bit index plus enable → 16-bit one-hot. Two instances, one for `Rout` (muxed between rb and rc) and one for `Rin` (ra).

## Test plan
- Reset: hold `clear` low 3 cycles → all outputs 0, `Run` = 0. Release → RESET for 1 cycle, then T0 with `PCout`, `IncPC`, `Zin` = 1.
- `and R1,R2,R3`: `IR` = `32'h28918000`, `MemRdy` = 1 → T3 `Rout` = `16'h0004` with `Yin`; T4 `Rout` = `16'h0008`, `aluControl` = `5'b00101`; T5 `Rin` = `16'h0002` with `Zlowout`. Next T0 at cycle 7.
- Memory wait: `MemRdy` low 3 cycles in T1 → T1 held 4 cycles, `PCin` high in the first cycle only, `IRin` asserts in the cycle after `MemRdy` rises.
- Timeout: `MemRdy` held low → after 15 wait cycles `MemErr` = 1, `Run` = 0, state HALT held until reset.
- HALT/NOP: `IR[31:27]` = `11010` → T3 then T0, no `Rin` asserted. `IR[31:27]` = `11011` → HALT, `Run` = 0.
- Async reset in T4: assert `clear` → `aluin`, `Zin`, and `Rout` drop in the same timestep, with no clock edge required.
